seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div.sv | 209 ++++++++++++++++++++
 tb/tb_seq_div.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
// Module   : seq_div
// Purpose  : Sequential restoring divider, 32/16 (word) or 16/8 (byte),
//            unsigned (DIV) or signed (IDIV, truncating toward zero), with
//            divide-by-zero / quotient-overflow exception reporting.
// Revision : 1.0  initial release
// ============================================================================
module seq_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] z,
  input  logic [15:0] d,
  input  logic        signed_op,
  input  logic        word_op,
  output logic        busy,
  output logic        done,
  output logic [15:0] q,
  output logic [15:0] r,
  output logic        exc
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:0]  ITER_WORD = 5'd16;
  localparam logic [4:0]  ITER_BYTE = 5'd8;
  localparam logic [15:0] QMAX_WORD = 16'd32767;
  localparam logic [15:0] QMAX_BYTE = 16'd127;

  state_t      state_q, state_d;
  logic [31:0] z_q, z_d;
  logic [15:0] d_q, d_d;
  logic        sgn_q, sgn_d;
  logic        word_q, word_d;
  logic [16:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [15:0] dvs_q, dvs_d;
  logic [15:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [15:0] q_q, q_d;
  logic [15:0] r_q, r_d;

  // Operand decode from the captured request: extension, signs, magnitudes.
  logic [31:0] z_ext, z_mag;
  logic [15:0] d_ext, d_mag, hi_mag;
  logic        z_neg, d_neg, hi_ge;
  always_comb begin
    if (word_q)     z_ext = z_q;
    else if (sgn_q) z_ext = {{16{z_q[15]}}, z_q[15:0]};
    else            z_ext = {16'h0000, z_q[15:0]};
    if (word_q)     d_ext = d_q;
    else if (sgn_q) d_ext = {{8{d_q[7]}}, d_q[7:0]};
    else            d_ext = {8'h00, d_q[7:0]};
    z_neg  = sgn_q & z_ext[31];
    d_neg  = sgn_q & d_ext[15];
    z_mag  = z_neg ? (32'd0 - z_ext) : z_ext;
    d_mag  = d_neg ? (16'd0 - d_ext) : d_ext;
    hi_mag = word_q ? z_mag[31:16] : {8'h00, z_mag[15:8]};
    // Quotient would need more bits than the result width.
    hi_ge  = (hi_mag >= d_mag);
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [16:0] shifted, diff;
  logic        take;
  always_comb begin
    shifted = {rem_q[15:0], dvd_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    take    = (shifted >= {1'b0, dvs_q});
  end

  // Sign fix-up of the magnitude results and signed range check.
  logic [15:0] q_mag, q_lim, q_sgn, r_sgn, q_fix, r_fix;
  logic        fix_exc;
  always_comb begin
    q_mag   = word_q ? quo_q : {8'h00, quo_q[7:0]};
    q_lim   = word_q ? QMAX_WORD : QMAX_BYTE;
    q_sgn   = (z_neg ^ d_neg) ? (16'd0 - q_mag) : q_mag;
    r_sgn   = z_neg ? (16'd0 - rem_q[15:0]) : rem_q[15:0];
    q_fix   = word_q ? q_sgn : {8'h00, q_sgn[7:0]};
    r_fix   = word_q ? r_sgn : {8'h00, r_sgn[7:0]};
    fix_exc = sgn_q & (hi_ge | (q_mag > q_lim));
  end

  // Next-state and next-output computation for the divider sequencer.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    d_d     = d_q;
    sgn_d   = sgn_q;
    word_d  = word_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    exc_d   = exc_q;
    q_d     = q_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          z_d     = z;
          d_d     = d;
          sgn_d   = signed_op;
          word_d  = word_op;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((d_ext == 16'h0000) || (!sgn_q && hi_ge)) begin
          exc_d   = 1'b1;
          q_d     = 16'h0000;
          r_d     = 16'h0000;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          rem_d   = {1'b0, hi_mag};
          dvd_d   = word_q ? {z_mag[15:0], 16'h0000} : {z_mag[7:0], 24'h000000};
          dvs_d   = d_mag;
          quo_d   = 16'h0000;
          cnt_d   = word_q ? ITER_WORD : ITER_BYTE;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = take ? diff : shifted;
        quo_d = {quo_q[14:0], take};
        dvd_d = {dvd_q[30:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_FIX;
      end
      S_FIX: begin
        exc_d   = fix_exc;
        q_d     = fix_exc ? 16'h0000 : q_fix;
        r_d     = fix_exc ? 16'h0000 : r_fix;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      z_q     <= 32'h0;
      d_q     <= 16'h0;
      sgn_q   <= 1'b0;
      word_q  <= 1'b0;
      rem_q   <= 17'h0;
      dvd_q   <= 32'h0;
      dvs_q   <= 16'h0;
      quo_q   <= 16'h0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      q_q     <= 16'h0;
      r_q     <= 16'h0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      d_q     <= d_d;
      sgn_q   <= sgn_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign exc  = exc_q;
  assign q    = q_q;
  assign r    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_div
// Purpose  : Directed self-checking bench for seq_div.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] z = 32'h0;
  logic [15:0] d = 16'h0;
  logic        signed_op = 1'b0;
  logic        word_op = 1'b0;
  logic        busy, done, exc;
  logic [15:0] q, r;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .z         (z),
    .d         (d),
    .signed_op (signed_op),
    .word_op   (word_op),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .exc       (exc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request across one capture edge, then scramble the inputs.
  task automatic launch(input logic [31:0] zi, input logic [15:0] di,
                        input logic s, input logic w);
    z = zi; d = di; signed_op = s; word_op = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; z = ~zi; d = ~di; signed_op = ~s; word_op = ~w;
  endtask

  // Called in cycle 1; returns the cycle index in which done is seen, or -1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] zi, input logic [15:0] di,
                     input logic s, input logic w, input int exp_lat,
                     input logic exp_exc, input logic [15:0] exp_q, input logic [15:0] exp_r);
    int lat;
    launch(zi, di, s, w);
    check($sformatf("%s.busy1", tag), busy, 1);
    wait_done(lat);
    check($sformatf("%s.lat", tag), lat, exp_lat);
    check($sformatf("%s.exc", tag), exc, exp_exc);
    check($sformatf("%s.q", tag), q, exp_q);
    check($sformatf("%s.r", tag), r, exp_r);
    check($sformatf("%s.busy_done", tag), busy, 0);
    @(posedge clk); #1;
    check($sformatf("%s.pulse", tag), done, 0);
    check($sformatf("%s.hold_q", tag), q, exp_q);
  endtask

  initial begin
    #(200_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Asynchronous reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.exc", exc, 0);
    check("rst.q", q, 0);
    check("rst.r", r, 0);
    check("rst.cnt", dut.cnt_q, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    //  tag        z             d        s     w     lat exc  q         r
    run("uword",   32'h00010000, 16'h0010, 1'b0, 1'b1, 19, 1'b0, 16'h1000, 16'h0000);
    run("sbyte",   32'hABCDFFF9, 16'hFF02, 1'b1, 1'b0, 11, 1'b0, 16'h00FD, 16'h00FF);
    run("divzero", 32'h00001234, 16'h0000, 1'b0, 1'b1,  2, 1'b1, 16'h0000, 16'h0000);
    run("uovf",    32'h00020000, 16'h0002, 1'b0, 1'b1,  2, 1'b1, 16'h0000, 16'h0000);
    run("sword_n", 32'hFFFFFF9C, 16'h0007, 1'b1, 1'b1, 19, 1'b0, 16'hFFF2, 16'hFFFE);
    run("sovf",    32'h80000000, 16'hFFFF, 1'b1, 1'b1, 19, 1'b1, 16'h0000, 16'h0000);
    run("ubyte",   32'h00001234, 16'h0056, 1'b0, 1'b0, 11, 1'b0, 16'h0036, 16'h0010);
    run("sb_m127", 32'h0000FF81, 16'h0001, 1'b1, 1'b0, 11, 1'b0, 16'h0081, 16'h0000);
    run("sb_ovf",  32'h00008000, 16'h00FF, 1'b1, 1'b0, 11, 1'b1, 16'h0000, 16'h0000);
    run("sw_rng",  32'hFFFF8000, 16'h0001, 1'b1, 1'b1, 19, 1'b1, 16'h0000, 16'h0000);
    run("sw_lim",  32'h00007FFF, 16'hFFFF, 1'b1, 1'b1, 19, 1'b0, 16'h8001, 16'h0000);

    // Reset in the middle of iterating: discarded, no done pulse.
    launch(32'h00123456, 16'h1234, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.q", q, 0);
    check("midrst.done", done, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst.nodone", done, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run("after_rst", 32'd100, 16'd7, 1'b0, 1'b1, 19, 1'b0, 16'h000E, 16'h0002);

    // Start held high through done: second capture only in the IDLE cycle after DONE.
    z = 32'd100; d = 16'd7; signed_op = 1'b0; word_op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    z = 32'd1000; d = 16'd9;
    wait_done(lat);
    check("b2b.lat1", lat, 19);
    check("b2b.q1", q, 16'h000E);
    check("b2b.r1", r, 16'h0002);
    @(posedge clk); #1;
    check("b2b.idle_busy", busy, 0);
    check("b2b.idle_done", done, 0);
    @(posedge clk); #1;
    check("b2b.busy2", busy, 1);
    start = 1'b0;
    wait_done(lat);
    check("b2b.lat2", lat, 19);
    check("b2b.q2", q, 16'h006F);
    check("b2b.r2", r, 16'h0001);
    check("b2b.exc2", exc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
